// File: rtl/imem_loader.sv
// imem_loader: boot-time instruction memory loader for the single-cycle MIPS core.
// Streams 32-bit words from a valid/ready source into instruction memory starting
// at word address 0, holding the processor in reset until the program is in place.
//
// Optional build macro: IMEM_LOADER_CHECKSUM_EN
//   When defined, the word tagged with load_last is a checksum (sum mod 2^32 of
//   all preceding words of the session). It is never written to memory. A match
//   releases the processor and a mismatch aborts the load.
//
// All outputs are registered. Each one is loaded from the next-state decode, so
// it always agrees with the state register.
module imem_loader #(
   parameter int ADDR_W     = 6,
   parameter int RESET_HOLD = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic [31:0]       load_data,
   input  logic              load_last,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              proc_reset,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   // The word counter is one bit wider than the address, so a completely full
   // memory (DEPTH words) can be represented.
   localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

   // Hold counter: counts 0 .. RESET_HOLD-1 while in HOLD.
   localparam int              HOLD_W    = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_ZERO = HOLD_W'(0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_HOLD  = 3'd2,
      ST_RUN   = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   state_t              state_r;
   state_t              state_s;
   logic [ADDR_W:0]     word_count_r;
   logic [ADDR_W:0]     count_s;
   logic [HOLD_W-1:0]   hold_cnt_r;
   logic [HOLD_W-1:0]   hold_s;
   logic                xfer_s;

   logic                load_ready_r;
   logic                imem_we_r;
   logic [ADDR_W-1:0]   imem_addr_r;
   logic [31:0]         imem_wdata_r;
   logic                proc_reset_r;
   logic                done_r;
   logic                error_r;

   logic                we_s;
   logic [ADDR_W-1:0]   addr_s;
   logic [31:0]         wdata_s;
   logic                ready_s;
   logic                proc_reset_s;
   logic                done_s;
   logic                error_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [31:0]         sum_r;
   logic [31:0]         sum_s;

   // Running checksum accumulate: modulo-2^32 sum of the instruction words.
   function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] word);
      return acc + word;
   endfunction
`endif

   // A transfer needs the registered LOAD state. It never depends on load_ready
   // feeding back combinationally.
   assign xfer_s = load_valid && (state_r == ST_LOAD);

   // Next-state, write-port and counter decode.
   always_comb begin
      state_s = state_r;
      count_s = word_count_r;
      hold_s  = hold_cnt_r;
      we_s    = 1'b0;
      addr_s  = imem_addr_r;
      wdata_s = imem_wdata_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_s   = sum_r;
`endif
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               state_s = ST_LOAD;
               count_s = {(ADDR_W+1){1'b0}};
`ifdef IMEM_LOADER_CHECKSUM_EN
               sum_s   = 32'd0;
`endif
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (xfer_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
               // The checksum word is never stored, so a full memory does not
               // reject it. The sum is checked and the word is dropped.
               if (load_last) begin
                  hold_s = HOLD_ZERO;
                  if (load_data == sum_r) begin
                     state_s = ST_HOLD;
                  end else begin
                     state_s = ST_ERROR;
                  end
               end else if (word_count_r == DEPTH_C) begin
                  state_s = ST_ERROR;
               end else begin
                  we_s    = 1'b1;
                  addr_s  = word_count_r[ADDR_W-1:0];
                  wdata_s = load_data;
                  count_s = word_count_r + CNT_ONE;
                  sum_s   = csum_add(sum_r, load_data);
                  state_s = ST_LOAD;
               end
`else
               if (word_count_r == DEPTH_C) begin
                  // Memory already full: drop the word and abort.
                  state_s = ST_ERROR;
               end else begin
                  we_s    = 1'b1;
                  addr_s  = word_count_r[ADDR_W-1:0];
                  wdata_s = load_data;
                  count_s = word_count_r + CNT_ONE;
                  if (load_last) begin
                     state_s = ST_HOLD;
                     hold_s  = HOLD_ZERO;
                  end else begin
                     state_s = ST_LOAD;
                  end
               end
`endif
            end else begin
               state_s = ST_LOAD;
            end
         end
         ST_HOLD: begin
            if (hold_cnt_r == HOLD_LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_HOLD;
               hold_s  = hold_cnt_r + HOLD_ONE;
            end
         end
         ST_RUN: begin
            state_s = ST_RUN;
         end
         ST_ERROR: begin
            state_s = ST_ERROR;
         end
         default: begin
            // An unknown encoding keeps the processor in reset.
            state_s = ST_ERROR;
         end
      endcase
   end

   // Status output decode from the next state, so the registered copies track the state register.
   always_comb begin
      ready_s      = 1'b0;
      proc_reset_s = 1'b1;
      done_s       = 1'b0;
      error_s      = 1'b0;
      case (state_s)
         ST_LOAD: begin
            ready_s = 1'b1;
         end
         ST_RUN: begin
            proc_reset_s = 1'b0;
            done_s       = 1'b1;
         end
         ST_ERROR: begin
            error_s = 1'b1;
         end
         default: begin
            ready_s      = 1'b0;
            proc_reset_s = 1'b1;
         end
      endcase
   end

   // State, counters and registered outputs. A synchronous reset cancels any pending write.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         word_count_r <= {(ADDR_W+1){1'b0}};
         hold_cnt_r   <= HOLD_ZERO;
         load_ready_r <= 1'b0;
         imem_we_r    <= 1'b0;
         imem_addr_r  <= {ADDR_W{1'b0}};
         imem_wdata_r <= 32'd0;
         proc_reset_r <= 1'b1;
         done_r       <= 1'b0;
         error_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         word_count_r <= count_s;
         hold_cnt_r   <= hold_s;
         load_ready_r <= ready_s;
         imem_we_r    <= we_s;
         imem_addr_r  <= addr_s;
         imem_wdata_r <= wdata_s;
         proc_reset_r <= proc_reset_s;
         done_r       <= done_s;
         error_r      <= error_s;
      end
   end

`ifdef IMEM_LOADER_CHECKSUM_EN
   // Checksum accumulator for the current session.
   always_ff @(posedge clk) begin
      if (reset) begin
         sum_r <= 32'd0;
      end else begin
         sum_r <= sum_s;
      end
   end
`endif

   assign load_ready = load_ready_r;
   assign imem_we    = imem_we_r;
   assign imem_addr  = imem_addr_r;
   assign imem_wdata = imem_wdata_r;
   assign proc_reset = proc_reset_r;
   assign done       = done_r;
   assign error      = error_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader. The stimulus drives whole load sessions and pushes the
// expected writes and the expected done/error cycles into queues. A monitor pops
// and checks those entries whenever the DUT shows a write or an outcome edge.
module tb_imem_loader;

   localparam int ADDR_W     = 3;
   localparam int RESET_HOLD = 2;
   localparam int DEPTH      = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              start = 1'b0;
   logic              load_valid = 1'b0;
   logic              load_ready;
   logic [31:0]       load_data = 32'd0;
   logic              load_last = 1'b0;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              proc_reset;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   imem_loader #(.ADDR_W(ADDR_W), .RESET_HOLD(RESET_HOLD)) dut (
      .clk(clk), .reset(reset), .start(start),
      .load_valid(load_valid), .load_ready(load_ready),
      .load_data(load_data), .load_last(load_last),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .proc_reset(proc_reset), .done(done), .error(error),
      .word_count(word_count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t exp_wr[$];
   int  exp_done_cyc[$];
   int  exp_err_cyc[$];
   logic [31:0] fixed_w [0:DEPTH];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_vals();
      check("rst_load_ready", 64'(load_ready), 64'd0);
      check("rst_imem_we",    64'(imem_we),    64'd0);
      check("rst_done",       64'(done),       64'd0);
      check("rst_error",      64'(error),      64'd0);
      check("rst_imem_addr",  64'(imem_addr),  64'd0);
      check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
      check("rst_word_count", 64'(word_count), 64'd0);
      check("rst_proc_reset", 64'(proc_reset), 64'd1);
   endtask

   // Monitor: every write and every done/error edge must match the next queued expectation.
   logic done_q = 1'b0;
   logic error_q = 1'b0;
   wr_t  mon_e;
   always @(negedge clk) begin
      if (imem_we) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_write", 64'(imem_we), 64'd0);
         end else begin
            mon_e = exp_wr.pop_front();
            check("write_addr", 64'(imem_addr), 64'(mon_e.addr));
            check("write_data", 64'(imem_wdata), 64'(mon_e.data));
         end
      end
      if (done && !done_q) begin
         if (exp_done_cyc.size() == 0) check("unexpected_done", 64'(done), 64'd0);
         else check("done_cycle", 64'(cyc), 64'(exp_done_cyc.pop_front()));
      end
      if (error && !error_q) begin
         if (exp_err_cyc.size() == 0) check("unexpected_error", 64'(error), 64'd0);
         else check("error_cycle", 64'(cyc), 64'(exp_err_cyc.pop_front()));
      end
      done_q  <= done;
      error_q <= error;
   end

   // One load session. n words are offered. With mark_last the final word carries load_last.
   // When rst_after >= 0, reset is asserted in the cycle after that transfer index.
   task automatic run_session(input int n, input bit mark_last, input int rst_after, input bit use_fixed);
      int          cnt;
      logic [31:0] sum;
      bit          fin;
      bit          was_reset;
      bit          exp_done;
      bit          exp_err;
      logic [31:0] w;
      bit          last;
      cnt = 0; sum = 32'd0; fin = 0; was_reset = 0; exp_done = 0; exp_err = 0;

      // Words offered before start must be ignored.
      repeat (2) begin
         load_valid = 1'b1;
         load_data  = $urandom;
         load_last  = 1'($urandom_range(0, 1));
         check("ready_idle", 64'(load_ready), 64'd0);
         step();
      end
      load_valid = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;

      for (int i = 0; i < n && !fin && !was_reset; i++) begin
         repeat ($urandom_range(0, 2)) begin
            load_valid = 1'b0;
            load_data  = $urandom;
            load_last  = 1'($urandom_range(0, 1));
            start      = 1'($urandom_range(0, 1));
            check("ready_gap", 64'(load_ready), 64'd1);
            step();
         end
         start = 1'($urandom_range(0, 1));
         w     = use_fixed ? fixed_w[i] : $urandom;
         last  = mark_last && (i == n - 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (last && !use_fixed && ($urandom_range(0, 1) == 1)) w = sum;
`endif
         check("ready_load", 64'(load_ready), 64'd1);
         load_valid = 1'b1;
         load_data  = w;
         load_last  = last;
`ifdef IMEM_LOADER_CHECKSUM_EN
         if (last) begin
            if (w == sum) begin
               exp_done = 1; exp_done_cyc.push_back(cyc + 1 + RESET_HOLD);
            end else begin
               exp_err = 1; exp_err_cyc.push_back(cyc + 1);
            end
            fin = 1;
         end else
`endif
         if (cnt == DEPTH) begin
            exp_err = 1;
            exp_err_cyc.push_back(cyc + 1);
            fin = 1;
         end else begin
            exp_wr.push_back('{addr: ADDR_W'(cnt), data: w});
            cnt++;
            sum = sum + w;
            if (last) begin
               exp_done = 1;
               exp_done_cyc.push_back(cyc + 1 + RESET_HOLD);
               fin = 1;
            end
         end
         step();
         if (i == rst_after) begin
            // This word would transfer, but reset wins, so it is never written.
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = 1'b0;
            reset      = 1'b1;
            step();
            check_reset_vals();
            reset      = 1'b0;
            load_valid = 1'b0;
            check("queue_after_reset", 64'(exp_wr.size()), 64'd0);
            exp_done_cyc.delete();
            exp_err_cyc.delete();
            was_reset = 1;
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      start      = 1'b0;

      if (!was_reset) begin
         for (int k = 0; k < 20 && !(done || error); k++) step();
         check("outcome_reached", 64'(done | error), 64'd1);
         @(negedge clk);
         #1;
         check("final_done",       64'(done),       64'(exp_done));
         check("final_error",      64'(error),      64'(exp_err));
         check("final_proc_reset", 64'(proc_reset), 64'(!exp_done));
         check("final_word_count", 64'(word_count), 64'(cnt));
         check("final_ready",      64'(load_ready), 64'd0);
         check("writes_drained",   64'(exp_wr.size()), 64'd0);
         check("done_drained",     64'(exp_done_cyc.size()), 64'd0);
         check("error_drained",    64'(exp_err_cyc.size()), 64'd0);
         // Stray start and words after the outcome change nothing.
         repeat (3) begin
            step();
            start = 1'b1; load_valid = 1'b1; load_data = $urandom;
         end
         step();
         start = 1'b0; load_valid = 1'b0;
         step(); step();
         check("stray_done",       64'(done),       64'(exp_done));
         check("stray_error",      64'(error),      64'(exp_err));
         check("stray_proc_reset", 64'(proc_reset), 64'(!exp_done));
         check("stray_word_count", 64'(word_count), 64'(cnt));
         reset = 1'b1;
         step();
         check_reset_vals();
         reset = 1'b0;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int mode;
      reset = 1'b1;
      step();
      step();
      check_reset_vals();
      reset = 1'b0;

`ifdef IMEM_LOADER_CHECKSUM_EN
      fixed_w[0] = 32'h00000001; fixed_w[1] = 32'h00000002; fixed_w[2] = 32'h00000003;
      run_session(3, 1'b1, -1, 1'b1);
      fixed_w[2] = 32'h00000004;
      run_session(3, 1'b1, -1, 1'b1);
`else
      fixed_w[0] = 32'h20080005; fixed_w[1] = 32'h20090003; fixed_w[2] = 32'h01095020;
      run_session(3, 1'b1, -1, 1'b1);
`endif
      run_session(DEPTH + 1, 1'b0, -1, 1'b0);   // overflow
      run_session(DEPTH, 1'b1, -1, 1'b0);       // exact fill
      run_session(4, 1'b1, 1, 1'b0);            // reset after the second transfer
      run_session(1, 1'b1, -1, 1'b0);           // single word

      for (int s = 0; s < 25; s++) begin
         mode = $urandom_range(0, 3);
         if (mode <= 1)      run_session($urandom_range(1, DEPTH + 1), 1'b1, -1, 1'b0);
         else if (mode == 2) run_session(DEPTH + 1, 1'b0, -1, 1'b0);
         else                run_session(4, 1'b1, $urandom_range(0, 2), 1'b0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
